cdec_controller: RTL



---
 rtl/cdec_pkg.sv | 78 +++++++
 rtl/cdec_branch_cond.sv | 25 ++
 rtl/cdec_controller.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cdec_pkg.sv
// Shared encodings for the CDEC control unit: bus selects, ALU ops, FSM states
// and instruction fields.
package cdec_pkg;

    localparam logic [2:0] XS_PC  = 3'd0;
    localparam logic [2:0] XS_A   = 3'd1;
    localparam logic [2:0] XS_B   = 3'd2;
    localparam logic [2:0] XS_C   = 3'd3;
    localparam logic [2:0] XS_R   = 3'd4;
    localparam logic [2:0] XS_RD  = 3'd5;
    localparam logic [2:0] XS_FLG = 3'd6;
    localparam logic [2:0] XS_FF  = 3'd7;

    localparam logic [2:0] XD_PC  = 3'd0;
    localparam logic [2:0] XD_A   = 3'd1;
    localparam logic [2:0] XD_B   = 3'd2;
    localparam logic [2:0] XD_C   = 3'd3;
    localparam logic [2:0] XD_MAR = 3'd4;
    localparam logic [2:0] XD_WDR = 3'd5;
    localparam logic [2:0] XD_T   = 3'd6;
    localparam logic [2:0] XD_I   = 3'd7;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_ADC  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SBB  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_INC  = 4'd8;
    localparam logic [3:0] ALU_PASS = 4'd9;

    localparam logic [1:0] OPC_MOV = 2'b00;
    localparam logic [1:0] OPC_ALU = 2'b01;
    localparam logic [1:0] OPC_MEM = 2'b10;
    localparam logic [1:0] OPC_JMP = 2'b11;

    localparam logic [1:0] RC_IMM = 2'b11;
    localparam logic [2:0] OP_CMP = 3'b111;

    localparam logic [2:0] CC_ALWAYS = 3'b000;
    localparam logic [2:0] CC_Z      = 3'b001;
    localparam logic [2:0] CC_NZ     = 3'b010;
    localparam logic [2:0] CC_CY     = 3'b011;
    localparam logic [2:0] CC_NCY    = 3'b100;
    localparam logic [2:0] CC_S      = 3'b101;
    localparam logic [2:0] CC_NS     = 3'b110;
    localparam logic [2:0] CC_HALT   = 3'b111;

    typedef enum logic [4:0] {
        ST_RST    = 5'd0,
        ST_FETCH0 = 5'd1,
        ST_FETCH1 = 5'd2,
        ST_FETCH2 = 5'd3,
        ST_OPND0  = 5'd4,
        ST_OPND1  = 5'd5,
        ST_MOVX   = 5'd6,
        ST_ALU0   = 5'd7,
        ST_ALU1   = 5'd8,
        ST_ALU2   = 5'd9,
        ST_MEMA   = 5'd10,
        ST_LDX    = 5'd11,
        ST_STW    = 5'd12,
        ST_MEMW   = 5'd13,
        ST_JMP    = 5'd14,
        ST_HALT   = 5'd15
    } cdec_state_e;

    // Register code to Xbus source; immediate operands come from RD.
    function automatic logic [2:0] reg_src(input logic [1:0] rc);
        if (rc == RC_IMM) begin
            return XS_RD;
        end else begin
            return {1'b0, rc} + 3'd1;
        end
    endfunction

endpackage

// File: rtl/cdec_branch_cond.sv
// Branch condition evaluator: decides whether a jump with code ccc is taken.
module cdec_branch_cond
    import cdec_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] SZCy,
    output logic       take
);

    // Flag test selected by the condition code; HALT never takes.
    always_comb begin
        take = 1'b0;
        case (ccc)
            CC_ALWAYS: take = 1'b1;
            CC_Z:      take = SZCy[1];
            CC_NZ:     take = ~SZCy[1];
            CC_CY:     take = SZCy[0];
            CC_NCY:    take = ~SZCy[0];
            CC_S:      take = SZCy[2];
            CC_NS:     take = ~SZCy[2];
            default:   take = 1'b0;
        endcase
    end

endmodule

// File: rtl/cdec_controller.sv
// CDEC multi-cycle control FSM: one Xbus micro-step per clock.
// Optional build macro CDEC_SINGLE_STEP_EN gates each instruction on a step pulse.
module cdec_controller
    import cdec_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] I,
    input  logic [2:0] SZCy,
    input  logic       step,
    output logic [2:0] xsrc,
    output logic [2:0] xdst,
    output logic [3:0] aluop,
    output logic       Rwe,
    output logic       FLGwe,
    output logic       MWe,
    output logic       halted,
    output logic [4:0] dbg_state
);

    cdec_state_e state_r;
    cdec_state_e dec_state_s;
    cdec_state_e opnd_next_s;
    logic        take_s;

    logic [1:0] opc_s;
    logic [1:0] rd_s;
    logic [1:0] rs_s;
    logic [2:0] op_s;
    logic       mem_st_s;
    logic       mem_c_s;

    assign opc_s    = I[7:6];
    assign op_s     = I[5:3];
    assign rd_s     = I[3:2];
    assign rs_s     = I[1:0];
    assign mem_st_s = I[5];
    assign mem_c_s  = I[4];
    assign dbg_state = state_r;

`ifdef CDEC_SINGLE_STEP_EN
    logic armed_r;
`else
    logic unused_step_s;
    assign unused_step_s = step;
`endif

    cdec_branch_cond u_branch (
        .ccc  (op_s),
        .SZCy (SZCy),
        .take (take_s)
    );

    // Successor of FETCH2 (decode) and of OPND1 (operand available on RD).
    always_comb begin
        dec_state_s = ST_OPND0;
        opnd_next_s = ST_MOVX;
        case (opc_s)
            OPC_MOV: begin
                dec_state_s = (rs_s == RC_IMM) ? ST_OPND0 : ST_MOVX;
                opnd_next_s = ST_MOVX;
            end
            OPC_ALU: begin
                dec_state_s = (rs_s == RC_IMM) ? ST_OPND0 : ST_ALU0;
                opnd_next_s = ST_ALU0;
            end
            OPC_MEM: begin
                dec_state_s = mem_c_s ? ST_MEMA : ST_OPND0;
                opnd_next_s = ST_MEMA;
            end
            default: begin
                dec_state_s = (op_s == CC_HALT) ? ST_HALT : ST_OPND0;
                opnd_next_s = ST_JMP;
            end
        endcase
    end

    // State register; reset forces RST from any state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RST;
`ifdef CDEC_SINGLE_STEP_EN
            armed_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_RST:    state_r <= ST_FETCH0;
`ifdef CDEC_SINGLE_STEP_EN
                ST_FETCH0: begin
                    if (armed_r) begin
                        state_r <= ST_FETCH1;
                        armed_r <= 1'b0;
                    end else if (step) begin
                        armed_r <= 1'b1;
                    end
                end
`else
                ST_FETCH0: state_r <= ST_FETCH1;
`endif
                ST_FETCH1: state_r <= ST_FETCH2;
                ST_FETCH2: state_r <= dec_state_s;
                ST_OPND0:  state_r <= ST_OPND1;
                ST_OPND1:  state_r <= opnd_next_s;
                ST_ALU0:   state_r <= ST_ALU1;
                ST_ALU1:   state_r <= (op_s == OP_CMP) ? ST_FETCH0 : ST_ALU2;
                ST_MEMA:   state_r <= mem_st_s ? ST_STW : ST_LDX;
                ST_STW:    state_r <= ST_MEMW;
                ST_HALT:   state_r <= ST_HALT;
                default:   state_r <= ST_FETCH0;
            endcase
        end
    end

    // Micro-op decode; anything not listed issues the NOP (T <= FF).
    always_comb begin
        xsrc   = XS_FF;
        xdst   = XD_T;
        aluop  = ALU_ADD;
        Rwe    = 1'b0;
        FLGwe  = 1'b0;
        MWe    = 1'b0;
        halted = 1'b0;
        case (state_r)
            ST_FETCH0: begin
`ifdef CDEC_SINGLE_STEP_EN
                if (armed_r) begin
                    xsrc  = XS_PC;
                    xdst  = XD_MAR;
                    aluop = ALU_INC;
                    Rwe   = 1'b1;
                end else begin
                    xsrc = XS_FF;
                end
`else
                xsrc  = XS_PC;
                xdst  = XD_MAR;
                aluop = ALU_INC;
                Rwe   = 1'b1;
`endif
            end
            ST_FETCH1: begin
                xsrc = XS_RD;
                xdst = XD_I;
            end
            ST_FETCH2, ST_OPND1: begin
                xsrc = XS_R;
                xdst = XD_PC;
            end
            ST_OPND0: begin
                xsrc  = XS_PC;
                xdst  = XD_MAR;
                aluop = ALU_INC;
                Rwe   = 1'b1;
            end
            ST_MOVX: begin
                if (rd_s != RC_IMM) begin
                    xsrc = reg_src(rs_s);
                    xdst = {1'b0, rd_s} + 3'd1;
                end else begin
                    xsrc = XS_FF;
                end
            end
            ST_ALU0: begin
                xsrc = reg_src(rs_s);
                xdst = XD_T;
            end
            ST_ALU1: begin
                xsrc  = XS_A;
                xdst  = XD_T;
                aluop = (op_s == OP_CMP) ? ALU_SUB : {1'b0, op_s};
                Rwe   = 1'b1;
                FLGwe = 1'b1;
            end
            ST_ALU2: begin
                xsrc = XS_R;
                xdst = XD_A;
            end
            ST_MEMA: begin
                xsrc = mem_c_s ? XS_C : XS_RD;
                xdst = XD_MAR;
            end
            ST_LDX: begin
                xsrc = XS_RD;
                xdst = XD_A;
            end
            ST_STW: begin
                xsrc = XS_A;
                xdst = XD_WDR;
            end
            ST_MEMW: MWe = 1'b1;
            ST_JMP: begin
                if (take_s) begin
                    xsrc = XS_RD;
                    xdst = XD_PC;
                end else begin
                    xsrc = XS_FF;
                end
            end
            ST_HALT: halted = 1'b1;
            default: halted = 1'b0;
        endcase
    end

endmodule
